// File: rtl/wb_mem_responder_pkg.sv
// Shared Wishbone definitions: bus widths, the request record and a byte-lane merge helper.
package wb_mem_responder_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic             we;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [WB_DW-1:0] merge_lanes(input logic [WB_DW-1:0] old_word,
                                                   input logic [WB_DW-1:0] new_word,
                                                   input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] merged;
    merged = old_word;
    for (int n = 0; n < WB_SW; n++) begin
      if (sel[n]) merged[8*n +: 8] = new_word[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_lat_pipe.sv
// Fixed-depth valid+data delay line; flush clears every valid bit at the next edge.
module wb_lat_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [W-1:0]       data_q [LATENCY];

  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Data needs no clearing: it is only observed when the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined SRAM slave: one accept per cycle, in-order acks after LATENCY cycles.
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WB_AW-1:0] wb_adr_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  output logic [WB_DW-1:0] wb_dat_o,
  input  logic             wb_we_i,
  input  logic [WB_SW-1:0] wb_sel_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  input  logic             wb_cyc_i,
  output logic             wb_stall_o,
  input  logic             stall_inj_i
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("wb_mem_responder: LATENCY must be in 1..4");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("wb_mem_responder: DEPTH must be a power of two >= 4");
    end
  endgenerate

  // Handshake: a request is taken at a rising edge when cyc & stb are high and
  // stall is low; each taken request produces exactly one ack, in order, unless
  // cyc drops or reset hits while it is still in flight.
  wb_req_t          req;
  logic             accept;
  logic             in_range;
  logic [AW-1:0]    word_idx;
  logic [WB_DW-1:0] rd_word;
  logic             flush;
  logic             pipe_vld;
  logic [WB_DW-1:0] pipe_dat;
  logic [1:0]       unused_adr_lsb;

  logic [WB_DW-1:0] mem [DEPTH];

  assign req = '{adr: wb_adr_i, dat: wb_dat_i, we: wb_we_i, sel: wb_sel_i};

  assign wb_stall_o     = stall_inj_i;
  assign accept         = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~rst_i;
  assign word_idx       = req.adr[AW+1:2];
  assign in_range       = ~|req.adr[WB_AW-1:AW+2];
  assign unused_adr_lsb = req.adr[1:0];

  // Writes carry zero through the pipe so wb_dat_o reads 0 on their ack.
  assign rd_word = (!req.we && in_range) ? mem[word_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (accept && req.we && in_range) begin
      mem[word_idx] <= merge_lanes(mem[word_idx], req.dat, req.sel);
    end
  end

  // Dropping cyc abandons the bus cycle, so in-flight responses are discarded.
  assign flush = rst_i | ~wb_cyc_i;

  wb_lat_pipe #(
    .LATENCY(LATENCY),
    .W      (WB_DW)
  ) u_pipe (
    .clk      (clk_i),
    .flush    (flush),
    .in_valid (accept),
    .in_data  (rd_word),
    .out_valid(pipe_vld),
    .out_data (pipe_dat)
  );

  assign wb_ack_o = pipe_vld & wb_cyc_i & ~rst_i;
  assign wb_dat_o = wb_ack_o ? pipe_dat : '0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: a LATENCY=1 and a LATENCY=3 responder, each driven from a vector table.
module tb_wb_mem_responder;

  typedef struct {
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        stall;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic        stall_inj [2];
  logic [31:0] adr [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic [3:0]  sel [2];
  logic        ack [2];
  logic        stall_o [2];

  vec_t tv[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]), .wb_dat_o(dat_r[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]), .wb_ack_o(ack[0]),
    .wb_cyc_i(cyc[0]), .wb_stall_o(stall_o[0]), .stall_inj_i(stall_inj[0])
  );

  wb_mem_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]), .wb_dat_o(dat_r[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]), .wb_ack_o(ack[1]),
    .wb_cyc_i(cyc[1]), .wb_stall_o(stall_o[1]), .stall_inj_i(stall_inj[1])
  );

  function automatic vec_t mk(logic r, logic c, logic s, logic w, logic st, logic [31:0] a,
                              logic [31:0] d, logic [3:0] sl, logic ea, logic [31:0] ed);
    vec_t v;
    v = '{rst: r, cyc: c, stb: s, we: w, stall: st, adr: a, dat: d, sel: sl,
          exp_ack: ea, exp_dat: ed};
    return v;
  endfunction

  function automatic vec_t wr(logic [31:0] a, logic [31:0] d, logic [3:0] sl, logic ea);
    return mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, d, sl, ea, 32'h0);
  endfunction

  function automatic vec_t rd(logic [31:0] a, logic ea, logic [31:0] ed);
    return mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, 32'h0, 4'hF, ea, ed);
  endfunction

  function automatic vec_t idle(logic ea, logic [31:0] ed);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ea, ed);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
  endtask

  task automatic park(int b);
    cyc[b] = 1'b0; stb[b] = 1'b0; we[b] = 1'b0; stall_inj[b] = 1'b0;
    adr[b] = 32'h0; dat_w[b] = 32'h0; sel[b] = 4'h0;
  endtask

  // Each vector drives its inputs ahead of one edge; outputs are sampled 1 ns after it.
  task automatic run_bus(int b, string tag);
    foreach (tv[i]) begin
      rst          = tv[i].rst;
      cyc[b]       = tv[i].cyc;
      stb[b]       = tv[i].stb;
      we[b]        = tv[i].we;
      stall_inj[b] = tv[i].stall;
      adr[b]       = tv[i].adr;
      dat_w[b]     = tv[i].dat;
      sel[b]       = tv[i].sel;
      @(posedge clk);
      #1;
      check({tag, "_ack"}, i, {31'h0, ack[b]}, {31'h0, tv[i].exp_ack});
      check({tag, "_dat"}, i, dat_r[b], tv[i].exp_dat);
      check({tag, "_stall"}, i, {31'h0, stall_o[b]}, {31'h0, tv[i].stall});
    end
    park(b);
    rst = 1'b0;
    tv.delete();
  endtask

  initial begin
    rst = 1'b1;
    park(0);
    park(1);

    // Reset with a write held on the bus: no ack, no data, and no commit.
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h99, 4'hF, 1'b0, 32'h0));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h99, 4'hF, 1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(wr(32'h50, 32'h0000_0001, 4'hF, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h99, 4'hF, 1'b0, 32'h0));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h99, 4'hF, 1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(rd(32'h50, 1'b1, 32'h0000_0001));
    // LATENCY=1 table: every vector sees its own response right after its edge.
    tv.push_back(wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1));
    tv.push_back(rd(32'h10, 1'b1, 32'hDEAD_BEEF));
    tv.push_back(wr(32'h20, 32'h1122_3344, 4'hF, 1'b1));
    tv.push_back(wr(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1));
    tv.push_back(rd(32'h20, 1'b1, 32'h11BB_33DD));
    tv.push_back(wr(32'h0, 32'hCAFE_F00D, 4'hF, 1'b1));
    tv.push_back(wr(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1));
    tv.push_back(rd(32'h1000, 1'b1, 32'h0));
    tv.push_back(rd(32'h0, 1'b1, 32'hCAFE_F00D));
    tv.push_back(wr(32'h4, 32'h55AA_55AA, 4'hF, 1'b1));
    tv.push_back(wr(32'h4, 32'h0, 4'h0, 1'b1));
    tv.push_back(rd(32'h4, 1'b1, 32'h55AA_55AA));
    tv.push_back(rd(32'h13, 1'b1, 32'hDEAD_BEEF));
    tv.push_back(wr(32'hFFC, 32'h0BAD_F00D, 4'hF, 1'b1));
    tv.push_back(rd(32'hFFC, 1'b1, 32'h0BAD_F00D));
    tv.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'hF, 1'b0, 32'h0));
    tv.push_back(wr(32'h8000_0010, 32'h1212_1212, 4'hF, 1'b1));
    tv.push_back(rd(32'h10, 1'b1, 32'hDEAD_BEEF));
    tv.push_back(idle(1'b0, 32'h0));
    run_bus(0, "l1");

    // LATENCY=3: preload, then four reads with one stalled cycle, then an abort.
    tv.push_back(wr(32'h0, 32'h1000_0000, 4'hF, 1'b0));
    tv.push_back(wr(32'h4, 32'h2000_0001, 4'hF, 1'b0));
    tv.push_back(wr(32'h8, 32'h3000_0002, 4'hF, 1'b1));
    tv.push_back(wr(32'hC, 32'h4000_0003, 4'hF, 1'b1));
    tv.push_back(idle(1'b1, 32'h0));
    tv.push_back(idle(1'b1, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(rd(32'h0, 1'b0, 32'h0));
    tv.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0));
    tv.push_back(rd(32'h4, 1'b1, 32'h1000_0000));
    tv.push_back(rd(32'h8, 1'b0, 32'h0));
    tv.push_back(rd(32'hC, 1'b1, 32'h2000_0001));
    tv.push_back(idle(1'b1, 32'h3000_0002));
    tv.push_back(idle(1'b1, 32'h4000_0003));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(rd(32'h0, 1'b0, 32'h0));
    tv.push_back(rd(32'h4, 1'b0, 32'h0));
    tv.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(rd(32'h8, 1'b0, 32'h0));
    tv.push_back(idle(1'b0, 32'h0));
    tv.push_back(idle(1'b1, 32'h3000_0002));
    tv.push_back(idle(1'b0, 32'h0));
    run_bus(1, "l3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
